// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Opcodes, FSM state encoding and byte-enable constants for
//               the MEM-stage bus access controller.
// Revision    : 1.0  initial release
// ============================================================================
package mem_access_pkg;

    localparam logic [5:0] c_OP_LW  = 6'b100011;
    localparam logic [5:0] c_OP_LH  = 6'b100001;
    localparam logic [5:0] c_OP_LHU = 6'b100101;
    localparam logic [5:0] c_OP_LB  = 6'b100000;
    localparam logic [5:0] c_OP_LBU = 6'b100100;
    localparam logic [5:0] c_OP_SW  = 6'b101011;
    localparam logic [5:0] c_OP_SH  = 6'b101001;
    localparam logic [5:0] c_OP_SB  = 6'b101000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_BE_ALL = 4'b1111;
    localparam logic [3:0] c_BE_HI  = 4'b1100;
    localparam logic [3:0] c_BE_LO  = 4'b0011;
    localparam logic [3:0] c_BE_B0  = 4'b0001;

    function automatic logic is_load(input logic [5:0] op);
        return (op == c_OP_LW) || (op == c_OP_LH) || (op == c_OP_LHU) ||
               (op == c_OP_LB) || (op == c_OP_LBU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == c_OP_SW) || (op == c_OP_SH) || (op == c_OP_SB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_load_extender.sv
`default_nettype none
// ============================================================================
// Module      : load_extender
// Description : Selects the addressed byte/half of a bus read word and
//               sign- or zero-extends it according to the load opcode.
// Revision    : 1.0  initial release
// ============================================================================
module load_extender
    import mem_access_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [5:0]  i_opcode,
    output logic [31:0] o_result
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    always_comb begin
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase

        case (i_opcode)
            c_OP_LH:  o_result = {{16{w_half[15]}}, w_half};
            c_OP_LHU: o_result = {16'h0000, w_half};
            c_OP_LB:  o_result = {{24{w_byte[7]}}, w_byte};
            c_OP_LBU: o_result = {24'h000000, w_byte};
            default:  o_result = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : MEM-stage controller that turns EX/MEM load/store fields into
//               a stalling request/ack bus access with timeout.
//               Optional macro MEM_ALIGN_CHECK_EN enables misalignment traps.
// Revision    : 1.0  initial release
// ============================================================================
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Inst_in,
    input  logic [31:0] AO_in,
    input  logic [31:0] rt_in,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] MO_out,
    output logic        bus_err,
    output logic        align_err
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_bus_req;
    logic               r_bus_we;
    logic [31:0]        r_bus_addr;
    logic [3:0]         r_bus_be;
    logic [31:0]        r_bus_wdata;
    logic [31:0]        r_mo;
    logic               r_bus_err;
    logic               r_align_err;
    logic [5:0]         r_op;
    logic [1:0]         r_ao_lo;

    logic [5:0]         w_op;
    logic               w_is_mem;
    logic               w_misaligned;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_ext;
    logic               w_unused;

    assign w_op     = Inst_in[31:26];
    assign w_is_mem = is_load(w_op) || is_store(w_op);
    assign w_unused = &{1'b0, Inst_in[25:0]};

    always_comb begin
        w_be    = c_BE_ALL;
        w_wdata = rt_in;
        case (w_op)
            c_OP_SH: begin
                w_be    = AO_in[1] ? c_BE_HI : c_BE_LO;
                w_wdata = {2{rt_in[15:0]}};
            end
            c_OP_SB: begin
                w_be    = c_BE_B0 << AO_in[1:0];
                w_wdata = {4{rt_in[7:0]}};
            end
            default: ;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        case (w_op)
            c_OP_LW, c_OP_SW:          w_misaligned = (AO_in[1:0] != 2'b00);
            c_OP_LH, c_OP_LHU, c_OP_SH: w_misaligned = AO_in[0];
            default:                   w_misaligned = 1'b0;
        endcase
    end
`else
    assign w_misaligned = 1'b0;
`endif

    load_extender u_load_extender (
        .i_rdata   (bus_rdata),
        .i_addr_lo (r_ao_lo),
        .i_opcode  (r_op),
        .o_result  (w_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
            r_mo        <= '0;
            r_bus_err   <= 1'b0;
            r_align_err <= 1'b0;
            r_op        <= '0;
            r_ao_lo     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_mem) begin
                        if (w_misaligned) begin
                            // Trap without touching the bus; MO_out keeps its value
                            r_state     <= ST_DONE;
                            r_align_err <= 1'b1;
                        end else begin
                            r_state     <= ST_WAIT;
                            r_cnt       <= '0;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= is_store(w_op);
                            r_bus_addr  <= {AO_in[31:2], 2'b00};
                            r_bus_be    <= w_be;
                            r_bus_wdata <= w_wdata;
                            r_op        <= w_op;
                            r_ao_lo     <= AO_in[1:0];
                        end
                    end
                end
                ST_WAIT: begin
                    // A late ack on the final counted cycle still wins over the timeout
                    if (bus_ack) begin
                        r_state   <= ST_DONE;
                        r_bus_req <= 1'b0;
                        if (is_load(r_op)) begin
                            r_mo <= w_ext;
                        end
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state   <= ST_DONE;
                        r_bus_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_mo      <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= '0;
                    r_bus_err   <= 1'b0;
                    r_align_err <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    assign stall     = (r_state == ST_WAIT) || ((r_state == ST_IDLE) && w_is_mem);
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_be    = r_bus_be;
    assign bus_wdata = r_bus_wdata;
    assign MO_out    = r_mo;
    assign bus_err   = r_bus_err;
    assign align_err = r_align_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Directed self-checking bench for mem_access (TIMEOUT_CYCLES=4).
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access;

    localparam int TO = 4;
    localparam logic [31:0] I_ADD = {6'b000000, 26'h0001234};
    localparam logic [31:0] I_LW  = {6'b100011, 26'h0};
    localparam logic [31:0] I_LH  = {6'b100001, 26'h0};
    localparam logic [31:0] I_LHU = {6'b100101, 26'h0};
    localparam logic [31:0] I_LB  = {6'b100000, 26'h0};
    localparam logic [31:0] I_LBU = {6'b100100, 26'h0};
    localparam logic [31:0] I_SW  = {6'b101011, 26'h0};
    localparam logic [31:0] I_SH  = {6'b101001, 26'h0};
    localparam logic [31:0] I_SB  = {6'b101000, 26'h0};

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Inst_in, AO_in, rt_in;
    logic        stall, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic [31:0] MO_out;
    logic        bus_err, align_err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .Inst_in   (Inst_in),
        .AO_in     (AO_in),
        .rt_in     (rt_in),
        .stall     (stall),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .MO_out    (MO_out),
        .bus_err   (bus_err),
        .align_err (align_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; Inst_in = I_ADD; AO_in = '0; rt_in = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        tick(); tick();
        n_total++;
        if ({bus_req, bus_we, bus_be, bus_err, align_err} !== 8'h00)
            $display("FAIL reset_ctl got req/we/be/err/aerr=%b want 00000000",
                     {bus_req, bus_we, bus_be, bus_err, align_err});
        else n_pass++;
        n_total++;
        if ({bus_addr, bus_wdata, MO_out} !== 96'h0)
            $display("FAIL reset_data got addr=%h wdata=%h mo=%h want all 0", bus_addr, bus_wdata, MO_out);
        else n_pass++;
        n_total++;
        if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall);
        else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_nonmem();
        Inst_in = I_ADD; bus_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            AO_in   = 32'h13 + i;
            bus_ack = i[0];
            #1;
            n_total++;
            if ({stall, bus_req} !== 2'b00 || MO_out !== 32'h0)
                $display("FAIL nonmem_%0d got stall=%b req=%b mo=%h want 0 0 00000000", i, stall, bus_req, MO_out);
            else n_pass++;
            tick();
        end
        bus_ack = 1'b0;
    endtask

    task automatic test_lb_wait2();
        int stall_cnt = 0;
        Inst_in = I_LB; AO_in = 32'h13; rt_in = '0; bus_ack = 1'b0; #1;
        if (stall === 1'b1) stall_cnt++;
        tick();
        n_total++;
        if ({bus_req, bus_we, bus_be, bus_addr} !== {1'b1, 1'b0, 4'hF, 32'h10})
            $display("FAIL lb_bus got req=%b we=%b be=%b addr=%h want 1 0 1111 00000010", bus_req, bus_we, bus_be, bus_addr);
        else n_pass++;
        if (stall === 1'b1) stall_cnt++;
        tick();
        bus_ack = 1'b1; bus_rdata = 32'h80FF_1234; #1;
        if (stall === 1'b1) stall_cnt++;
        tick();
        bus_ack = 1'b0; #1;
        n_total++;
        if (MO_out !== 32'hFFFF_FF80) $display("FAIL lb_mo got %h want ffffff80", MO_out);
        else n_pass++;
        n_total++;
        if ({stall, bus_req, bus_err} !== 3'b000 || stall_cnt != 3)
            $display("FAIL lb_stall got done stall/req/err=%b high_cycles=%0d want 000 3", {stall, bus_req, bus_err}, stall_cnt);
        else n_pass++;
        tick();
    endtask

    // One access with ack in its first WAIT cycle; ends in IDLE so calls chain back-to-back
    task automatic test_access(input logic [31:0] inst, input logic [31:0] ao, input logic [31:0] rt,
                               input logic [31:0] rdata, input logic [31:0] e_addr, input logic e_we,
                               input logic [3:0] e_be, input logic [31:0] e_wdata,
                               input logic [31:0] e_mo, input string name);
        Inst_in = inst; AO_in = ao; rt_in = rt; #1;
        n_total++;
        if (stall !== 1'b1) $display("FAIL %s_idle_stall got %b want 1", name, stall);
        else n_pass++;
        tick();
        bus_ack = 1'b1; bus_rdata = rdata; #1;
        n_total++;
        if ({bus_req, stall, bus_we, bus_be, bus_addr} !== {1'b1, 1'b1, e_we, e_be, e_addr})
            $display("FAIL %s_bus got req=%b stall=%b we=%b be=%b addr=%h want 1 1 %b %b %h",
                     name, bus_req, stall, bus_we, bus_be, bus_addr, e_we, e_be, e_addr);
        else n_pass++;
        if (e_we) begin
            n_total++;
            if (bus_wdata !== e_wdata) $display("FAIL %s_wdata got %h want %h", name, bus_wdata, e_wdata);
            else n_pass++;
        end
        tick();
        bus_ack = 1'b0; #1;
        n_total++;
        if ({stall, bus_req, bus_err} !== 3'b000 || MO_out !== e_mo)
            $display("FAIL %s_done got stall/req/err=%b mo=%h want 000 %h", name, {stall, bus_req, bus_err}, MO_out, e_mo);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        test_access(I_SH,  32'h22,  32'h0000_ABCD, 32'h0,         32'h20,  1'b1, 4'b1100, 32'hABCD_ABCD, 32'hFFFF_FF80, "sh");
        test_access(I_SB,  32'h01,  32'h1234_565A, 32'h0,         32'h00,  1'b1, 4'b0010, 32'h5A5A_5A5A, 32'hFFFF_FF80, "sb");
        test_access(I_SW,  32'h104, 32'hDEAD_BEEF, 32'h0,         32'h104, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'hFFFF_FF80, "sw");
        test_access(I_LBU, 32'h02,  32'h0,         32'h80FF_1234, 32'h00,  1'b0, 4'b1111, 32'h0,         32'h0000_00FF, "lbu");
        test_access(I_LH,  32'h02,  32'h0,         32'h80FF_1234, 32'h00,  1'b0, 4'b1111, 32'h0,         32'hFFFF_80FF, "lh");
        test_access(I_LHU, 32'h00,  32'h0,         32'h80FF_1234, 32'h00,  1'b0, 4'b1111, 32'h0,         32'h0000_1234, "lhu");
        test_access(I_LB,  32'h01,  32'h0,         32'h80FF_1234, 32'h00,  1'b0, 4'b1111, 32'h0,         32'h0000_0012, "lb1");
        test_access(I_LW,  32'h08,  32'h0,         32'h80FF_1234, 32'h08,  1'b0, 4'b1111, 32'h0,         32'h80FF_1234, "lw");
        test_access(I_SH,  32'h00,  32'hFFFF_0055, 32'h0,         32'h00,  1'b1, 4'b0011, 32'h0055_0055, 32'h80FF_1234, "sh0");
        Inst_in = I_ADD;
    endtask

    task automatic test_timeout();
        Inst_in = I_LW; AO_in = 32'h40; bus_ack = 1'b0; #1;
        tick();
        for (int i = 0; i < TO; i++) begin
            n_total++;
            if ({bus_req, stall, bus_err} !== 3'b110)
                $display("FAIL timeout_wait%0d got req/stall/err=%b want 110", i, {bus_req, stall, bus_err});
            else n_pass++;
            tick();
        end
        n_total++;
        if ({bus_err, stall, bus_req} !== 3'b100 || MO_out !== 32'h0)
            $display("FAIL timeout_done got err/stall/req=%b mo=%h want 100 00000000", {bus_err, stall, bus_req}, MO_out);
        else n_pass++;
        Inst_in = I_ADD;
        tick();
        n_total++;
        if (bus_err !== 1'b0) $display("FAIL timeout_err_clear got %b want 0", bus_err);
        else n_pass++;
    endtask

    task automatic test_ack_at_limit();
        Inst_in = I_LW; AO_in = 32'h0; bus_ack = 1'b0; #1;
        tick(); tick(); tick(); tick();
        bus_ack = 1'b1; bus_rdata = 32'h1357_2468; #1;
        tick();
        bus_ack = 1'b0; #1;
        n_total++;
        if (bus_err !== 1'b0 || MO_out !== 32'h1357_2468)
            $display("FAIL ack_at_limit got err=%b mo=%h want 0 13572468", bus_err, MO_out);
        else n_pass++;
        Inst_in = I_ADD;
        tick();
    endtask

    task automatic test_reset_in_wait();
        Inst_in = I_LW; AO_in = 32'h50; bus_ack = 1'b0; #1;
        tick(); tick();
        reset = 1'b1; Inst_in = I_ADD;
        tick();
        n_total++;
        if ({bus_req, stall, bus_err} !== 3'b000 || MO_out !== 32'h0 || bus_addr !== 32'h0)
            $display("FAIL rst_wait got req/stall/err=%b mo=%h addr=%h want 000 0 0", {bus_req, stall, bus_err}, MO_out, bus_addr);
        else n_pass++;
        reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hAAAA_5555;
        tick();
        bus_ack = 1'b0; #1;
        n_total++;
        if ({bus_req, bus_err} !== 2'b00 || MO_out !== 32'h0)
            $display("FAIL rst_wait_idle got req/err=%b mo=%h want 00 00000000", {bus_req, bus_err}, MO_out);
        else n_pass++;
    endtask

    task automatic test_align();
`ifdef MEM_ALIGN_CHECK_EN
        Inst_in = I_LW; AO_in = 32'h6; #1;
        n_total++;
        if (stall !== 1'b1) $display("FAIL align_idle_stall got %b want 1", stall);
        else n_pass++;
        tick();
        n_total++;
        if ({align_err, bus_req, stall} !== 3'b100 || MO_out !== 32'h0)
            $display("FAIL align_done got aerr/req/stall=%b mo=%h want 100 00000000", {align_err, bus_req, stall}, MO_out);
        else n_pass++;
        Inst_in = I_ADD;
        tick();
        n_total++;
        if (align_err !== 1'b0) $display("FAIL align_clear got %b want 0", align_err);
        else n_pass++;
`else
        test_access(I_LW, 32'h6, 32'h0, 32'hCAFE_F00D, 32'h4, 1'b0, 4'b1111, 32'h0, 32'hCAFE_F00D, "lw_unal");
        Inst_in = I_ADD; #1;
        n_total++;
        if (align_err !== 1'b0) $display("FAIL align_tied got %b want 0", align_err);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_lb_wait2();
        test_back_to_back();
        test_timeout();
        test_ack_at_limit();
        test_reset_in_wait();
        test_align();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
